// File: rtl/input_conditioner_pkg.sv
// input_cond_pkg: shared constants and helpers for the input conditioner.
//   clog2        - constant function, ceil(log2(v)), 0 for v <= 1
//   GLITCH_CNT_W - width of each per-channel rejected-glitch counter
//   NSYNC_MIN    - smallest synchronizer depth accepted at elaboration
//   NSYNC_MAX    - largest synchronizer depth accepted at elaboration
package input_cond_pkg;

  localparam int GLITCH_CNT_W = 8;
  localparam int NSYNC_MIN    = 2;
  localparam int NSYNC_MAX    = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/input_conditioner_cond_channel.sv
// cond_channel: one input channel -- NSYNC-stage synchronizer, debounce
// counter, stable level register, registered rise/fall pulses and, when
// INPUT_COND_GLITCH_CNT_EN is defined, a saturating rejected-glitch counter.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   in         raw asynchronous input
//   level      debounced stable level
//   rise       one-cycle pulse on level 0->1
//   fall       one-cycle pulse on level 1->0
//   glitch_cnt rejected-glitch count (INPUT_COND_GLITCH_CNT_EN only)
module cond_channel
  import input_cond_pkg::*;
#(
  parameter int   NSYNC           = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
`ifdef INPUT_COND_GLITCH_CNT_EN
  output logic fall,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`else
  output logic fall
`endif
);

  // A single-cycle debounce needs no count range, but keep one bit so the
  // counter vector stays legal.
  localparam int CW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [NSYNC-1:0] r_sync;
  logic [CW-1:0]    r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_s;

  assign w_s = r_sync[NSYNC-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= {NSYNC{RESET_LEVEL}};
      r_level <= RESET_LEVEL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[NSYNC-2:0], in};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM_CNT) begin
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

`ifdef INPUT_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch;

  // A nonzero count while the input agrees with level means a bounce
  // ended before it was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= '0;
    end else if ((w_s == r_level) && (r_cnt != '0) && (r_glitch != '1)) begin
      r_glitch <= r_glitch + 1'b1;
    end
  end

  assign glitch_cnt = r_glitch;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel synchronizer / debounce / edge-detect
// front end between external pins and the traffic FSM.
// Optional feature macro: INPUT_COND_GLITCH_CNT_EN (adds glitch_cnt).
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   in         raw asynchronous inputs, WIDTH bits
//   level      debounced stable levels
//   rise       one-cycle pulses on level 0->1
//   fall       one-cycle pulses on level 1->0
//   glitch_cnt per-channel rejected-glitch counts, channel i at [8i+7:8i]
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               NSYNC           = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
`ifdef INPUT_COND_GLITCH_CNT_EN
  output logic [WIDTH-1:0] fall,
  output logic [GLITCH_CNT_W*WIDTH-1:0] glitch_cnt
`else
  output logic [WIDTH-1:0] fall
`endif
);

  if (NSYNC < NSYNC_MIN || NSYNC > NSYNC_MAX) begin : g_bad_nsync
    $error("input_conditioner: NSYNC must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    cond_channel #(
      .NSYNC           (NSYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[g])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .in         (in[g]),
      .level      (level[g]),
      .rise       (rise[g]),
`ifdef INPUT_COND_GLITCH_CNT_EN
      .fall       (fall[g]),
      .glitch_cnt (glitch_cnt[GLITCH_CNT_W*g +: GLITCH_CNT_W])
`else
      .fall       (fall[g])
`endif
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
`ifdef INPUT_COND_GLITCH_CNT_EN
  logic [31:0] glitch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  input_conditioner #(
    .WIDTH           (4),
    .NSYNC           (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (4'b1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .level      (level),
    .rise       (rise),
`ifdef INPUT_COND_GLITCH_CNT_EN
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
`else
    .fall       (fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance n edges expecting no change: level stays at lvl, no pulses.
  task automatic quiet(input int n, input logic [3:0] lvl, input string tag);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_level"}, 32'(level), 32'(lvl));
      chk({tag, "_pulse"}, 32'({rise, fall}), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 4'b1000;
    step();
    step();
    chk("rst_level", 32'(level), 32'h8);
    chk("rst_pulse", 32'({rise, fall}), 32'd0);
    rst = 1'b0;

    // 1: idle after reset
    quiet(6, 4'b1000, "t1");
`ifdef INPUT_COND_GLITCH_CNT_EN
    chk("t1_glitch", glitch_cnt, 32'd0);
`endif

    // 2: in[0] rises; accepted on the 6th edge
    in[0] = 1'b1;
    quiet(5, 4'b1000, "t2_wait");
    step();
    chk("t2_level", 32'(level), 32'h9);
    chk("t2_rise",  32'(rise),  32'h1);
    chk("t2_fall",  32'(fall),  32'h0);
    step();
    chk("t2_rise_off", 32'(rise), 32'h0);
    chk("t2_fall_off", 32'(fall), 32'h0);

    // 3: three-cycle glitch on in[1] is rejected
    in[1] = 1'b1;
    quiet(3, 4'b1001, "t3_hi");
    in[1] = 1'b0;
    quiet(6, 4'b1001, "t3_lo");
`ifdef INPUT_COND_GLITCH_CNT_EN
    chk("t3_glitch", 32'(glitch_cnt[15:8]), 32'd1);
    chk("t3_glitch_ch0", 32'(glitch_cnt[7:0]), 32'd0);
`endif

    // in[0] back low so channel 0 idles at 0
    in[0] = 1'b0;
    quiet(5, 4'b1001, "t3b_wait");
    step();
    chk("t3b_level", 32'(level), 32'h8);
    chk("t3b_fall",  32'(fall),  32'h1);
    chk("t3b_rise",  32'(rise),  32'h0);

    // 4: simultaneous opposite transitions on channels 3 and 2
    in = 4'b0100;
    quiet(5, 4'b1000, "t4_wait");
    step();
    chk("t4_level", 32'(level), 32'h4);
    chk("t4_rise",  32'(rise),  32'h4);
    chk("t4_fall",  32'(fall),  32'h8);
    step();
    chk("t4_pulse_off", 32'({rise, fall}), 32'd0);

    // 5: reset mid-debounce drops the pending transition
    in = 4'b1001;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_level", 32'(level), 32'h8);
    chk("t5_rst_pulse", 32'({rise, fall}), 32'd0);
`ifdef INPUT_COND_GLITCH_CNT_EN
    chk("t5_rst_glitch", glitch_cnt, 32'd0);
`endif
    quiet(5, 4'b1000, "t5_wait");
    step();
    chk("t5_level", 32'(level), 32'h9);
    chk("t5_rise",  32'(rise),  32'h1);
    chk("t5_fall",  32'(fall),  32'h0);

    // 6: 300 rejected glitches on in[1]
    for (int g = 0; g < 300; g++) begin
      in[1] = 1'b1;
      for (int k = 0; k < 3; k++) step();
      in[1] = 1'b0;
      for (int k = 0; k < 3; k++) step();
      if (g == 9) begin
`ifdef INPUT_COND_GLITCH_CNT_EN
        chk("t6_glitch_10", 32'(glitch_cnt[15:8]), 32'd10);
`endif
        chk("t6_level_10", 32'(level), 32'h9);
      end
    end
    quiet(4, 4'b1001, "t6_end");
`ifdef INPUT_COND_GLITCH_CNT_EN
    chk("t6_glitch_sat", 32'(glitch_cnt[15:8]), 32'd255);
    chk("t6_glitch_others", 32'({glitch_cnt[31:16], glitch_cnt[7:0]}), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Multi-channel front end for asynchronous traffic-controller inputs: pedestrian buttons, vehicle loop sensors and manual override switches.
- Per channel it provides an NSYNC-stage synchronizer, then a debounce filter, then registered rise/fall edge pulses.
- Sits between the top-level pins and the traffic FSM; every external input reaches the FSM only through this block.

Parameters:
- WIDTH, 4: number of independent input channels.
- NSYNC, 2: synchronizer flop stages per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized value must differ from the stable level before the level is accepted; legal range ≥1.
- RESET_LEVEL, {WIDTH{1'b0}}: per-channel reset value of the sync flops and stable levels; set a bit to 1 for active-low inputs.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  raw asynchronous inputs.
- level  output  WIDTH  debounced stable level per channel.
- rise  output  WIDTH  one-cycle pulse when level goes 0→1.
- fall  output  WIDTH  one-cycle pulse when level goes 1→0.
- glitch_cnt  output  8*WIDTH  per-channel rejected-glitch count; present only with the optional feature, channel i at bits [8i+7:8i].

Behaviour:
- One clock and one synchronous active-high reset, named clk and rst. All state updates on posedge clk.
- Reset (rst=1 at an edge):
  - sync flops ← RESET_LEVEL; level ← RESET_LEVEL; debounce counters ← 0; rise, fall ← 0; glitch_cnt ← 0.
  - No edge pulse is generated by reset or on the first cycle after reset.
- Synchronizer: in[i] shifts through NSYNC flops. s[i] is the output of the last stage.
- Debounce, per channel, counter width CW = clog2(DEBOUNCE_CYCLES). Each cycle:
  - s == level: counter ← 0.
  - s != level and counter == DEBOUNCE_CYCLES-1: level ← s, counter ← 0, and the matching rise/fall bit is set to 1 for exactly one cycle.
  - s != level otherwise: counter ← counter+1.
- Latency: a clean input change settled before edge 0 appears on level (and rise/fall) after edge NSYNC+DEBOUNCE_CYCLES.
- rise/fall are registered and coincide with the cycle in which level first shows the new value.
  - rise & fall are never both 1 on a channel.
  - A pulse is never longer than 1 cycle.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES leaves level unchanged and clears the counter on the first matching cycle.
- A bounce that returns to the opposite value restarts the count from 0 on the next mismatch; counts do not accumulate across runs.
- Channels are fully independent; simultaneous events on several channels are all handled in the same cycle.
- rst asserted mid-debounce discards partial counts; an in-flight transition is lost and no pulse is produced.

Optional Feature:
- Macro INPUT_COND_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt port exists.
  - Per channel, an 8-bit counter increments on each cycle where s == level and the debounce counter != 0, i.e. a rejected bounce.
  - The counter saturates at 255 and clears only on rst.
- Not defined: port and counters are absent; behaviour otherwise identical.

Decomposition:
- Package input_cond_pkg:
  - clog2 constant function.
  - GLITCH_CNT_W = 8.
  - NSYNC_MIN = 2.
- Sub-module cond_channel: one channel's synchronizer, debounce counter, level register, edge pulses and optional glitch counter.
- input_conditioner is a generate loop instantiating WIDTH cond_channel copies. Parameter legality is checked at elaboration.

Test Plan (WIDTH=4, NSYNC=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=4'b1000):
1. Release rst with in=4'b1000.
   - Expect level=4'b1000, rise=fall=0 on every cycle.
   - Expect glitch_cnt=0.
2. in[0] 0→1 held.
   - Expect level[0]=1 and rise[0]=1 exactly 6 edges after the change.
   - Expect rise[0]=0 the next cycle; fall never asserted.
3. in[1] pulses high for 3 cycles, then low.
   - Expect level[1] to stay 0 and no pulse.
   - With the macro defined: glitch_cnt[15:8]=1.
4. in[3] 1→0 and in[2] 0→1 toggled on the same cycle.
   - Expect fall[3] and rise[2] asserted together 6 edges later.
   - Expect level=4'b0100 with in[0] still 0.
5. in[0] held high for 3 cycles after changing, then rst asserted for 1 cycle.
   - Expect level[0]=0 after reset and no rise[0].
   - The channel then debounces afresh: rise[0] 6 edges after rst deasserts if in[0] stays 1.
6. With the macro defined, drive 300 three-cycle glitches on in[1].
   - Expect glitch_cnt[15:8] saturates at 255 and level[1] stays 0.
